// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO write side: arbiter state encoding
// and the almost-full slack used by the write-side flag logic.
package afifo_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  localparam int unsigned ALMOST_FULL_SLACK = 2;

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority search: the first set bit of req, starting just after
// index last and wrapping modulo N_REQ. Purely combinational.
module rr_picker
  import afifo_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         pick,
  output logic [$clog2(N_REQ)-1:0] pick_idx
);

  localparam int unsigned IW = $clog2(N_REQ);

  logic          found;
  int unsigned   cand;
  logic [IW-1:0] idx;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = 0;
    idx      = '0;
    // Offsets 1..N_REQ visit every requester once, ending at last itself.
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = (32'(last) + i) % N_REQ;
      idx  = IW'(cand);
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/w_arbiter.sv
// Packet-granular round-robin arbiter for the async FIFO write port.
// A grant lasts until the owner's last beat or the MAX_BURST beat cap.
module w_arbiter
  import afifo_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        full,
  input  logic                        almost_full,
  output logic                        w_en,
  output logic [DATA_WIDTH-1:0]       w_data,
  output logic [N_REQ-1:0]            grant,
  output logic                        busy
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);

  arb_state_t    state;
  logic [IW-1:0] last_grant;
  logic [CW-1:0] beat_cnt;

  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             owner_valid;
  logic             owner_last;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req      (req_valid),
    .last     (last_grant),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // Everything below is masked by grant, so it all drops to zero in IDLE.
  assign owner_valid = |(req_valid & grant);
  assign owner_last  = |(req_last & grant);
  assign req_ready   = grant & {N_REQ{~full}};
  assign w_en        = owner_valid & ~full;

  always_comb begin
    w_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) w_data = w_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      busy       <= 1'b0;
      last_grant <= IW'(N_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|req_valid && !almost_full) begin
            state      <= ARB_BURST;
            grant      <= pick;
            busy       <= 1'b1;
            last_grant <= pick_idx;
            beat_cnt   <= '0;
          end
        end
        ARB_BURST: begin
          if (w_en) begin
            if (owner_last || beat_cnt == CAP) begin
              state    <= ARB_IDLE;
              grant    <= '0;
              busy     <= 1'b0;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ARB_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_w_arbiter.sv
// Directed bench for w_arbiter (N_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_w_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        full;
  logic        almost_full;
  logic        w_en;
  logic [7:0]  w_data;
  logic [3:0]  grant;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  w_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .full        (full),
    .almost_full (almost_full),
    .w_en        (w_en),
    .w_data      (w_data),
    .grant       (grant),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int r, input logic [7:0] d, input logic l);
    req_data[r*8 +: 8] = d;
    req_last[r]        = l;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    full = 1'b0; almost_full = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = '0; req_last = '0; req_data = '0;
    full = 1'b0; almost_full = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL rst_grant got %b want 0000", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (w_en !== 1'b0) begin n_err++; $display("FAIL rst_w_en got %b want 0", w_en); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready got %b want 0000", req_ready); end
    n_cmp++; if (w_data !== 8'h00) begin n_err++; $display("FAIL rst_w_data got %h want 00", w_data); end
    tick();
    rst = 1'b1;
    // requester 1 alone: gets the first grant, then sends two beats
    req_valid = 4'b0010;
    set_data(1, 8'h10, 1'b0);
    tick();
    n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL rst_pre_grant got %b want 0010", grant); end
    tick();
    set_data(1, 8'h11, 1'b0);
    tick();
    set_data(1, 8'h12, 1'b0);
    #1;
    n_cmp++; if (dut.beat_cnt !== 3'd2) begin n_err++; $display("FAIL rst_pre_cnt got %0d want 2", dut.beat_cnt); end
    n_cmp++; if (w_en !== 1'b1) begin n_err++; $display("FAIL rst_pre_w_en got %b want 1", w_en); end
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (w_en !== 1'b0) begin n_err++; $display("FAIL rst_mid_w_en got %b want 0", w_en); end
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL rst_mid_grant got %b want 0000", grant); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_mid_ready got %b want 0000", req_ready); end
    n_cmp++; if (w_data !== 8'h00) begin n_err++; $display("FAIL rst_mid_w_data got %h want 00", w_data); end
    req_valid = 4'b1111;
    set_data(0, 8'hA0, 1'b1);
    set_data(1, 8'h10, 1'b1);
    rst = 1'b1;
    tick();
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL rst_first_grant got %b want 0001", grant); end
    n_cmp++; if (w_data !== 8'hA0) begin n_err++; $display("FAIL rst_first_data got %h want a0", w_data); end
  endtask

  task automatic test_round_robin();
    int writes;
    int slot;
    logic [3:0] eg;
    do_reset();
    writes = 0;
    req_valid = 4'b1111;
    for (int r = 0; r < 4; r++) set_data(r, 8'(8'h30 + r), 1'b1);
    for (int e = 1; e <= 10; e++) begin
      tick();
      slot = ((e - 1) / 2) % 4;
      eg = (e % 2 == 1) ? 4'(1 << slot) : 4'b0000;
      n_cmp++; if (grant !== eg) begin n_err++; $display("FAIL rr_grant edge %0d got %b want %b", e, grant, eg); end
      n_cmp++; if (w_en !== (e % 2 == 1)) begin n_err++; $display("FAIL rr_w_en edge %0d got %b want %b", e, w_en, (e % 2 == 1)); end
      if (e % 2 == 1) begin
        n_cmp++; if (w_data !== 8'(8'h30 + slot)) begin n_err++; $display("FAIL rr_w_data edge %0d got %h want %h", e, w_data, 8'(8'h30 + slot)); end
      end
      if (w_en === 1'b1) writes++;
    end
    n_cmp++; if (writes !== 5) begin n_err++; $display("FAIL rr_writes got %0d want 5", writes); end
  endtask

  task automatic test_burst_cap();
    logic [7:0] pat;
    int beat;
    int exp_beat;
    logic fire;
    do_reset();
    pat = 8'b0110_1111;
    beat = 0;
    exp_beat = 0;
    req_valid = 4'b0100;
    set_data(2, 8'h20, 1'b0);
    for (int e = 0; e < 8; e++) begin
      fire = req_valid[2] & req_ready[2];
      tick();
      if (fire) begin
        beat++;
        if (beat == 6) req_valid = 4'b0000;
        else set_data(2, 8'(8'h20 + beat), (beat == 5));
      end
      #1;
      n_cmp++; if (w_en !== pat[e]) begin n_err++; $display("FAIL cap_w_en cycle %0d got %b want %b", e, w_en, pat[e]); end
      n_cmp++; if (grant !== (pat[e] ? 4'b0100 : 4'b0000)) begin n_err++; $display("FAIL cap_grant cycle %0d got %b want %b", e, grant, (pat[e] ? 4'b0100 : 4'b0000)); end
      if (pat[e]) begin
        n_cmp++; if (w_data !== 8'(8'h20 + exp_beat)) begin n_err++; $display("FAIL cap_w_data cycle %0d got %h want %h", e, w_data, 8'(8'h20 + exp_beat)); end
        exp_beat++;
      end
    end
    n_cmp++; if (beat !== 6) begin n_err++; $display("FAIL cap_beats got %0d want 6", beat); end
  endtask

  task automatic test_full_stall();
    do_reset();
    req_valid = 4'b0001;
    set_data(0, 8'hA0, 1'b0);
    tick();
    n_cmp++; if (w_en !== 1'b1 || w_data !== 8'hA0) begin n_err++; $display("FAIL stall_beat0 got w_en=%b data=%h want 1/a0", w_en, w_data); end
    tick();
    set_data(0, 8'hA1, 1'b0);
    full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      #1;
      n_cmp++; if (w_en !== 1'b0) begin n_err++; $display("FAIL stall_w_en cycle %0d got %b want 0", k, w_en); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall_ready cycle %0d got %b want 0000", k, req_ready); end
      n_cmp++; if (dut.beat_cnt !== 3'd1) begin n_err++; $display("FAIL stall_cnt cycle %0d got %0d want 1", k, dut.beat_cnt); end
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL stall_grant cycle %0d got %b want 0001", k, grant); end
    end
    tick();
    full = 1'b0;
    #1;
    n_cmp++; if (w_en !== 1'b1 || w_data !== 8'hA1) begin n_err++; $display("FAIL stall_resume got w_en=%b data=%h want 1/a1", w_en, w_data); end
    tick();
    set_data(0, 8'hA2, 1'b1);
    #1;
    n_cmp++; if (w_en !== 1'b1 || w_data !== 8'hA2) begin n_err++; $display("FAIL stall_last got w_en=%b data=%h want 1/a2", w_en, w_data); end
    tick();
    req_valid = 4'b0000;
    n_cmp++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL stall_end got grant=%b busy=%b want 0000/0", grant, busy); end
  endtask

  task automatic test_almost_full();
    do_reset();
    almost_full = 1'b1;
    req_valid = 4'b0010;
    set_data(1, 8'h40, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL af_hold cycle %0d got grant=%b busy=%b want 0000/0", k, grant, busy); end
    end
    almost_full = 1'b0;
    tick();
    n_cmp++; if (grant !== 4'b0010 || w_en !== 1'b1 || w_data !== 8'h40) begin n_err++; $display("FAIL af_grant got grant=%b w_en=%b data=%h want 0010/1/40", grant, w_en, w_data); end
    almost_full = 1'b1;
    #1;
    n_cmp++; if (w_en !== 1'b1) begin n_err++; $display("FAIL af_mid0 got %b want 1", w_en); end
    tick();
    set_data(1, 8'h41, 1'b0);
    #1;
    n_cmp++; if (w_en !== 1'b1 || w_data !== 8'h41 || grant !== 4'b0010) begin n_err++; $display("FAIL af_mid1 got w_en=%b data=%h grant=%b want 1/41/0010", w_en, w_data, grant); end
    tick();
    set_data(1, 8'h42, 1'b1);
    #1;
    n_cmp++; if (w_en !== 1'b1 || w_data !== 8'h42) begin n_err++; $display("FAIL af_mid2 got w_en=%b data=%h want 1/42", w_en, w_data); end
    tick();
    req_valid = 4'b0000;
    almost_full = 1'b0;
    n_cmp++; if (grant !== 4'b0000 || w_en !== 1'b0) begin n_err++; $display("FAIL af_end got grant=%b w_en=%b want 0000/0", grant, w_en); end
  endtask

  task automatic test_owner_bubble();
    do_reset();
    req_valid = 4'b0111;
    set_data(0, 8'h50, 1'b0);
    set_data(1, 8'h61, 1'b1);
    set_data(2, 8'h72, 1'b1);
    tick();
    n_cmp++; if (grant !== 4'b0001 || w_data !== 8'h50) begin n_err++; $display("FAIL bub_start got grant=%b data=%h want 0001/50", grant, w_data); end
    tick();
    set_data(0, 8'h51, 1'b0);
    req_valid[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) tick();
      #1;
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL bub_grant cycle %0d got %b want 0001", k, grant); end
      n_cmp++; if (w_en !== 1'b0) begin n_err++; $display("FAIL bub_w_en cycle %0d got %b want 0", k, w_en); end
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bub_ready cycle %0d got %b want 0001", k, req_ready); end
      n_cmp++; if (dut.beat_cnt !== 3'd1) begin n_err++; $display("FAIL bub_cnt cycle %0d got %0d want 1", k, dut.beat_cnt); end
    end
    tick();
    req_valid[0] = 1'b1;
    #1;
    n_cmp++; if (w_en !== 1'b1 || w_data !== 8'h51) begin n_err++; $display("FAIL bub_resume got w_en=%b data=%h want 1/51", w_en, w_data); end
    tick();
    set_data(0, 8'h52, 1'b1);
    #1;
    n_cmp++; if (w_en !== 1'b1 || w_data !== 8'h52) begin n_err++; $display("FAIL bub_last got w_en=%b data=%h want 1/52", w_en, w_data); end
    tick();
    req_valid[0] = 1'b0;
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL bub_idle got %b want 0000", grant); end
    tick();
    n_cmp++; if (grant !== 4'b0010 || w_data !== 8'h61) begin n_err++; $display("FAIL bub_next got grant=%b data=%h want 0010/61", grant, w_data); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    full = 1'b0; almost_full = 1'b0;
    test_reset();
    test_round_robin();
    test_burst_cap();
    test_full_stall();
    test_almost_full();
    test_owner_bubble();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
